mdu_iter: RTL



---
 rtl/mdu_iter_if.sv | 14 +
 rtl/mdu_iter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mdu_iter_if.sv
// Request/result bundle between the register-file read stage and the multiply/divide unit.
interface mdu_iter_if #(parameter int WIDTH = 32);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             Busy;
  logic             Done;

  modport master (output Start, Op, A, B, input HI, LO, Busy, Done);
  modport slave  (input Start, Op, A, B, output HI, LO, Busy, Done);
endinterface

// File: rtl/mdu_iter.sv
// Iterative MIPS multiply/divide unit: one shift-add or restoring-divide step per cycle,
// owns HI/LO and raises Busy for the WIDTH cycles of a MULT/MULTU/DIV/DIVU.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input logic        CLK,
  input logic        RST_N,
  mdu_iter_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_t;

  // Per-operation control latched at the accepting edge.
  typedef struct packed {
    logic             is_div;
    logic             div0;
    logic             neg_q;   // sign of quotient, or of the product for multiplies
    logic             neg_r;   // remainder follows the dividend's sign
    logic [WIDTH-1:0] a_raw;
  } ctl_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  ctl_t             ctl;
  logic [WIDTH-1:0] ma, mb, ph, pl;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q;

  op_t              op;
  logic             is_signed, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    op        = op_t'(bus.Op);
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    sa        = is_signed & bus.A[WIDTH-1];
    sb        = is_signed & bus.B[WIDTH-1];
    mag_a     = sa ? -bus.A : bus.A;
    mag_b     = sb ? -bus.B : bus.B;
  end

  // One iteration. Multiply: ph:pl holds partial product with the multiplier
  // shifting out of pl. Divide: ph is the partial remainder, pl shifts dividend
  // bits out and quotient bits in.
  logic [WIDTH:0]   sum, shifted;
  logic [WIDTH-1:0] diff, nh, nl;
  logic             ge;

  always_comb begin
    sum     = {1'b0, ph} + {1'b0, ({WIDTH{pl[0]}} & ma)};
    shifted = {ph, pl[WIDTH-1]};
    ge      = shifted >= {1'b0, mb};
    diff    = shifted[WIDTH-1:0] - mb;
    nh      = sum[WIDTH:1];
    nl      = {sum[0], pl[WIDTH-1:1]};
    if (ctl.is_div) begin
      nh = ge ? diff : shifted[WIDTH-1:0];
      nl = {pl[WIDTH-2:0], ge};
    end
  end

  // Sign correction applied to the values produced by the final iteration.
  logic [2*WIDTH-1:0] prod, prod_c;
  logic [WIDTH-1:0]   q_c, r_c, res_hi, res_lo;

  always_comb begin
    prod   = {nh, nl};
    prod_c = ctl.neg_q ? -prod : prod;
    q_c    = ctl.neg_q ? -nl : nl;
    r_c    = ctl.neg_r ? -nh : nh;
    res_hi = prod_c[2*WIDTH-1:WIDTH];
    res_lo = prod_c[WIDTH-1:0];
    if (ctl.is_div) begin
      res_hi = ctl.div0 ? ctl.a_raw : r_c;
      res_lo = ctl.div0 ? {WIDTH{1'b1}} : q_c;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= IDLE;
      cnt    <= '0;
      ctl    <= '0;
      ma     <= '0;
      mb     <= '0;
      ph     <= '0;
      pl     <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                ctl.is_div <= (op == OP_DIV) || (op == OP_DIVU);
                ctl.div0   <= ((op == OP_DIV) || (op == OP_DIVU)) && (bus.B == '0);
                ctl.neg_q  <= sa ^ sb;
                ctl.neg_r  <= sa;
                ctl.a_raw  <= bus.A;
                ma         <= mag_a;
                mb         <= (op == OP_DIV || op == OP_DIVU) ? mag_b : mag_a;
                pl         <= (op == OP_DIV || op == OP_DIVU) ? mag_a : mag_b;
                ph         <= '0;
                cnt        <= '0;
                busy_q     <= 1'b1;
                state      <= RUN;
              end
              OP_MTHI: hi_q <= bus.A;
              OP_MTLO: lo_q <= bus.A;
              default: ;
            endcase
          end
        end
        RUN: begin
          ph  <= nh;
          pl  <= nl;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) begin
            hi_q   <= res_hi;
            lo_q   <= res_lo;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            cnt    <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
endmodule
